// File: rtl/spi_load_master.sv
// SPI/QPI master for the SoC memory-load port: one 32-bit word write or read per request
// (command, address, optional dummy, data), SPI mode 0, MSB-first on one or four lanes.
module spi_load_master #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned DUMMY_CYCLES = 32,
    parameter logic [7:0]  WR_CMD       = 8'h02,
    parameter logic [7:0]  RD_CMD       = 8'h0B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        qpi_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        spi_sck_o,
    output logic        spi_csn_o,
    output logic [3:0]  spi_sdo_o,
    input  logic [3:0]  spi_sdi_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD, GAP} state_t;

    localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [8:0]  div_cnt_reg, div_cnt_next;
    logic [7:0]  cyc_cnt_reg, cyc_cnt_next;
    logic        sck_reg, sck_next;
    logic        csn_reg, csn_next;
    logic [3:0]  sdo_reg, sdo_next;
    logic        drive_reg, drive_next;
    logic [71:0] tx_reg, tx_next;
    logic [31:0] rx_reg, rx_next;
    logic        we_reg, we_next;
    logic        qpi_reg, qpi_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rdata_reg, rdata_next;

    logic [3:0]  lane_bits;
    logic [7:0]  phase_last;
    logic        half_done;

    assign half_done = (div_cnt_reg == HALF_LAST);

    // Lane 0 carries the serial bit in single mode; in quad mode lane 3 is the nibble MSB.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi == 0) begin : g_lane0
                assign lane_bits[gi] = qpi_next ? tx_next[68] : tx_next[71];
            end else begin : g_laneq
                assign lane_bits[gi] = qpi_next & tx_next[68 + gi];
            end
        end
    endgenerate

    assign sdo_next = drive_next ? lane_bits : 4'b0000;

    always_comb begin
        phase_last = 8'd0;
        case (state_reg)
            CMD:     phase_last = qpi_reg ? 8'd1 : 8'd7;
            ADDR:    phase_last = qpi_reg ? 8'd7 : 8'd31;
            DUMMY:   phase_last = DUMMY_LAST;
            DATA:    phase_last = qpi_reg ? 8'd7 : 8'd31;
            default: phase_last = 8'd0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = div_cnt_reg;
        cyc_cnt_next   = cyc_cnt_reg;
        sck_next       = sck_reg;
        csn_next       = csn_reg;
        drive_next     = drive_reg;
        tx_next        = tx_reg;
        rx_next        = rx_reg;
        we_next        = we_reg;
        qpi_next       = qpi_reg;
        rsp_valid_next = 1'b0;
        rdata_next     = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    state_next   = CMD;
                    csn_next     = 1'b0;
                    sck_next     = 1'b0;
                    div_cnt_next = 9'd0;
                    cyc_cnt_next = 8'd0;
                    we_next      = req_we_i;
                    qpi_next     = qpi_i;
                    tx_next      = {(req_we_i ? WR_CMD : RD_CMD), req_addr_i, req_wdata_i};
                    rx_next      = 32'd0;
                    drive_next   = 1'b1;
                end
            end

            CMD, ADDR, DUMMY, DATA: begin
                if (!half_done) begin
                    div_cnt_next = div_cnt_reg + 9'd1;
                end else begin
                    div_cnt_next = 9'd0;
                    if (!sck_reg) begin
                        sck_next = 1'b1;
                        if (state_reg == DATA && !we_reg) begin
                            rx_next = qpi_reg ? {rx_reg[27:0], spi_sdi_i}
                                              : {rx_reg[30:0], spi_sdi_i[0]};
                        end
                    end else begin
                        // Falling edge: advance the transmit stream and the phase.
                        sck_next = 1'b0;
                        if (state_reg != DUMMY) begin
                            tx_next = qpi_reg ? {tx_reg[67:0], 4'b0000}
                                              : {tx_reg[70:0], 1'b0};
                        end
                        if (cyc_cnt_reg == phase_last) begin
                            cyc_cnt_next = 8'd0;
                            case (state_reg)
                                CMD:  state_next = ADDR;
                                ADDR: begin
                                    state_next = we_reg ? DATA : DUMMY;
                                    drive_next = we_reg;
                                end
                                DUMMY: state_next = DATA;
                                default: begin
                                    state_next = HOLD;
                                    drive_next = 1'b0;
                                end
                            endcase
                        end else begin
                            cyc_cnt_next = cyc_cnt_reg + 8'd1;
                        end
                    end
                end
            end

            HOLD: begin
                if (half_done) begin
                    state_next     = GAP;
                    div_cnt_next   = 9'd0;
                    csn_next       = 1'b1;
                    rsp_valid_next = 1'b1;
                    if (!we_reg) begin
                        rdata_next = rx_reg;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 9'd1;
                end
            end

            GAP: begin
                if (div_cnt_reg == GAP_LAST) begin
                    state_next   = IDLE;
                    div_cnt_next = 9'd0;
                end else begin
                    div_cnt_next = div_cnt_reg + 9'd1;
                end
            end

            default: begin
                state_next = IDLE;
                csn_next   = 1'b1;
                sck_next   = 1'b0;
                drive_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            div_cnt_reg   <= 9'd0;
            cyc_cnt_reg   <= 8'd0;
            sck_reg       <= 1'b0;
            csn_reg       <= 1'b1;
            sdo_reg       <= 4'b0000;
            drive_reg     <= 1'b0;
            tx_reg        <= 72'd0;
            rx_reg        <= 32'd0;
            we_reg        <= 1'b0;
            qpi_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= 32'd0;
        end else begin
            state_reg     <= state_next;
            div_cnt_reg   <= div_cnt_next;
            cyc_cnt_reg   <= cyc_cnt_next;
            sck_reg       <= sck_next;
            csn_reg       <= csn_next;
            sdo_reg       <= sdo_next;
            drive_reg     <= drive_next;
            tx_reg        <= tx_next;
            rx_reg        <= rx_next;
            we_reg        <= we_next;
            qpi_reg       <= qpi_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign req_ready_o = (state_reg == IDLE);
    assign busy_o      = (state_reg != IDLE);
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_rdata_o = rdata_reg;
    assign spi_sck_o   = sck_reg;
    assign spi_csn_o   = csn_reg;
    assign spi_sdo_o   = sdo_reg;

endmodule

// File: doc/spi_load_master.md
Name: spi_load_master

Overview:
- Synthesizable SPI/QPI master that issues 32-bit word writes and reads to the SoC's SPI slave memory-load port.
- It is the initiator end of the protocol the chip's SPI slave answers, and replaces the bench's task-based loader.
- Used in bench and FPGA bring-up to push program images into L2 and read them back through spi_clk/spi_cs/sdi/sdo.
- Issues one transaction per request: command, address, optional dummy, data.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period; legal range 1..255.
- DUMMY_CYCLES, 32, SCK cycles between address and read data; legal range 1..255; used for reads only.
- WR_CMD, 8'h02, command byte for a word write.
- RD_CMD, 8'h0B, command byte for a word read.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  master idle and able to accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  32  target byte address.
- req_wdata_i  in  32  write data.
- qpi_i  in  1  1 = quad lanes for all phases, 0 = single lane.
- rsp_valid_o  out  1  one-cycle transaction-done pulse.
- rsp_rdata_o  out  32  read data.
- spi_sck_o  out  1  SPI clock, mode 0.
- spi_csn_o  out  1  chip select, active low.
- spi_sdo_o  out  4  master-to-slave data lanes.
- spi_sdi_i  in  4  slave-to-master data lanes.
- busy_o  out  1  inverse of req_ready_o.

Behaviour:
- Reset values: req_ready_o=1, busy_o=0, spi_csn_o=1, spi_sck_o=0, spi_sdo_o=0, rsp_valid_o=0, rsp_rdata_o=0.
- Reset mid-transaction takes effect on the next edge: CSN high, SCK low, all counters cleared, no rsp pulse.
- Handshake:
  - A request is accepted when req_valid_i && req_ready_o on a clk edge.
  - req_we_i, req_addr_i, req_wdata_i and qpi_i are latched at acceptance.
  - req_ready_o drops in the same cycle the request is accepted.
  - Requests presented while busy are ignored.
- States: IDLE, CMD, ADDR, DUMMY, DATA, HOLD, GAP.
  - IDLE -> CMD on acceptance; CSN falls and the first bit is driven on the following edge.
  - CMD: 8 bits. ADDR: 32 bits.
  - Write: ADDR -> DATA (TX 32 bits).
  - Read: ADDR -> DUMMY (DUMMY_CYCLES SCK cycles, sdo=0) -> DATA (RX 32 bits, sdo=0).
  - DATA -> HOLD -> GAP -> IDLE.
- Lane mapping:
  - All fields are MSB-first.
  - Single mode: 1 bit per SCK on sdo[0]; sdo[3:1]=0; sampled from sdi[0].
  - Quad mode: 1 nibble per SCK, sdo[3] carries the nibble MSB; sampled from sdi[3:0].
  - Quad applies to CMD, ADDR and DATA; DUMMY length is independent of mode.
- SCK timing, with N = total SCK cycles:
  - First rising edge occurs CLK_DIV clk after CSN falls.
  - Each SCK cycle is high for CLK_DIV clk, then low for CLK_DIV clk.
  - Outputs change together with each falling edge.
  - RX bits are sampled at the rising edge.
  - After the N-th falling edge, HOLD lasts CLK_DIV clk, then CSN rises.
  - CSN is low for (2N+1)*CLK_DIV clk.
- N values:
  - Single write: 72.
  - Quad write: 18.
  - Single read: 72+DUMMY_CYCLES.
  - Quad read: 18+DUMMY_CYCLES.
- Completion:
  - rsp_valid_o pulses for 1 clk in the cycle CSN rises, for both reads and writes.
  - For reads, rsp_rdata_o updates in that same cycle and is held until the next read completes.
  - Writes leave rsp_rdata_o unchanged.
- GAP: CSN stays high for 2*CLK_DIV clk, then req_ready_o=1. Minimum spacing between transactions is guaranteed.
- spi_sdo_o is 0 whenever CSN is high.

Test Plan:
- Reset, then idle 20 cycles -> csn=1, sck=0, sdo=0, ready=1, rsp_valid never asserted.
- CLK_DIV=2, single write addr 0x0000_0010, data 0xDEADBEEF -> serial stream 0x02,0x00000010,0xDEADBEEF on sdo[0]; CSN low 290 clk; one rsp_valid; slave model memory holds 0xDEADBEEF.
- CLK_DIV=2, qpi=1 write addr 0x0010_0000, data 0x12345678 -> 18 SCK cycles, nibbles 0,2,0,0,1,0,0,0,0,0,1,2,3,4,5,6,7,8; CSN low 74 clk.
- CLK_DIV=2, DUMMY_CYCLES=32, qpi=1 read of 0x0010_0000 with slave returning 0xCAFEF00D -> CSN low 202 clk; rsp_rdata=0xCAFEF00D on the rsp_valid cycle; value held through a following write.
- Back-to-back: req_valid held high with 2 requests -> second accepted only after 2*CLK_DIV clk with CSN high; a request during busy is not accepted.
- rst asserted at clk 100 of a single write -> next cycle csn=1, sck=0, ready=1, no rsp pulse; a new write then completes normally.
